// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one external combinational ALU between
// the slc3 datapath sequencer (requester 0) and the path-search engine (requester 1).
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request; grant is offered combinationally
// EXEC  | operands registered on alu_*, ALU result settling
// RESP  | result registered on rsp_*, waiting for rsp_ready
module alu_share_arbiter #(
    parameter int WIDTH = 16,
    parameter int OPW   = 2
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_A,
    input  logic [WIDTH-1:0] req0_B,
    input  logic [OPW-1:0]   req0_ALUK,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_A,
    input  logic [WIDTH-1:0] req1_B,
    input  logic [OPW-1:0]   req1_ALUK,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic [OPW-1:0]   alu_ALUK,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id,
    output logic             busy
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] EXEC = 2'b01;
    localparam logic [1:0] RESP = 2'b10;

    logic [1:0] state;
    logic       last_grant;
    logic       grant_id;
    logic       grant_valid;

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        grant_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid)
            grant_id = ~last_grant;
        else
            grant_id = req1_valid;
    end

    assign req0_ready = (state == IDLE) && req0_valid && !grant_id;
    assign req1_ready = (state == IDLE) && req1_valid && grant_id;
    assign busy       = (state != IDLE);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            alu_A      <= '0;
            alu_B      <= '0;
            alu_ALUK   <= '1;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_id     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        alu_A      <= grant_id ? req1_A    : req0_A;
                        alu_B      <= grant_id ? req1_B    : req0_B;
                        alu_ALUK   <= grant_id ? req1_ALUK : req0_ALUK;
                        rsp_id     <= grant_id;
                        last_grant <= grant_id;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= alu_out;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: table of single operations, then
// contention, backpressure and reset-in-flight sequences.
module tb_alu_share_arbiter;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic        req0_valid, req0_ready;
    logic [15:0] req0_A, req0_B;
    logic [1:0]  req0_ALUK;
    logic        req1_valid, req1_ready;
    logic [15:0] req1_A, req1_B;
    logic [1:0]  req1_ALUK;
    logic [15:0] alu_A, alu_B;
    logic [1:0]  alu_ALUK;
    logic [15:0] alu_out;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_id;
    logic        busy;

    int checks = 0;
    int failures = 0;

    alu_share_arbiter #(.WIDTH(16), .OPW(2)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_A(req0_A), .req0_B(req0_B), .req0_ALUK(req0_ALUK),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_A(req1_A), .req1_B(req1_B), .req1_ALUK(req1_ALUK),
        .alu_A(alu_A), .alu_B(alu_B), .alu_ALUK(alu_ALUK), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
    );

    always #5 Clk = ~Clk;

    // Stand-in for the external ALU.
    always_comb begin
        alu_out = alu_A;
        case (alu_ALUK)
            2'b00: alu_out = alu_A + alu_B;
            2'b01: alu_out = alu_A & alu_B;
            2'b10: alu_out = ~alu_A;
            default: alu_out = alu_A;
        endcase
    end

    typedef struct {
        logic        id;
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  aluk;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_op(input vec_t v);
        rsp_ready = 1'b1;
        if (v.id == 1'b0) begin
            req0_valid = 1'b1; req0_A = v.a; req0_B = v.b; req0_ALUK = v.aluk;
        end else begin
            req1_valid = 1'b1; req1_A = v.a; req1_B = v.b; req1_ALUK = v.aluk;
        end
        #1;
        check("op_ready0", {31'd0, req0_ready}, {31'd0, ~v.id});
        check("op_ready1", {31'd0, req1_ready}, {31'd0, v.id});
        check("op_idle_busy", {31'd0, busy}, 32'd0);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        check("exec_busy", {31'd0, busy}, 32'd1);
        check("exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("exec_alu_A", {16'd0, alu_A}, {16'd0, v.a});
        check("exec_alu_ALUK", {30'd0, alu_ALUK}, {30'd0, v.aluk});
        check("exec_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        step();
        check("resp_valid", {31'd0, rsp_valid}, 32'd1);
        check("resp_data", {16'd0, rsp_data}, {16'd0, v.exp});
        check("resp_id", {31'd0, rsp_id}, {31'd0, v.id});
        check("resp_busy", {31'd0, busy}, 32'd1);
        step();
        check("done_valid", {31'd0, rsp_valid}, 32'd0);
        check("done_busy", {31'd0, busy}, 32'd0);
        check("hold_alu_A", {16'd0, alu_A}, {16'd0, v.a});
    endtask

    initial begin
        vecs[0] = '{id: 1'b0, a: 16'h0005, b: 16'h0003, aluk: 2'b00, exp: 16'h0008};
        vecs[1] = '{id: 1'b1, a: 16'hFFFF, b: 16'h0002, aluk: 2'b00, exp: 16'h0001};
        vecs[2] = '{id: 1'b0, a: 16'hF0F0, b: 16'h0FF0, aluk: 2'b01, exp: 16'h00F0};
        vecs[3] = '{id: 1'b1, a: 16'h00FF, b: 16'h0000, aluk: 2'b10, exp: 16'hFF00};
        vecs[4] = '{id: 1'b0, a: 16'h1234, b: 16'h5555, aluk: 2'b11, exp: 16'h1234};
        vecs[5] = '{id: 1'b1, a: 16'hABCD, b: 16'h0001, aluk: 2'b11, exp: 16'hABCD};

        req0_valid = 0; req0_A = 0; req0_B = 0; req0_ALUK = 0;
        req1_valid = 0; req1_A = 0; req1_B = 0; req1_ALUK = 0;
        rsp_ready = 0;

        #1 Reset_n = 1'b0;
        #1;
        check("rst_alu_A", {16'd0, alu_A}, 32'd0);
        check("rst_alu_B", {16'd0, alu_B}, 32'd0);
        check("rst_alu_ALUK", {30'd0, alu_ALUK}, 32'd3);
        check("rst_rsp", {14'd0, rsp_valid, rsp_id, rsp_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        step();
        check("idle_no_req_busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 6; i++) do_op(vecs[i]);

        // Contention from reset: req0 wins the first tie, then strict alternation.
        #1 Reset_n = 1'b0;
        #1 Reset_n = 1'b1;
        req0_valid = 1; req0_A = 16'hF0F0; req0_B = 16'h0FF0; req0_ALUK = 2'b01;
        req1_valid = 1; req1_A = 16'h00FF; req1_B = 16'h0000; req1_ALUK = 2'b10;
        rsp_ready = 1;
        #1;
        for (int op = 0; op < 6; op++) begin
            logic exp_id;
            exp_id = op[0];
            check("cont_ready0", {31'd0, req0_ready}, {31'd0, ~exp_id});
            check("cont_ready1", {31'd0, req1_ready}, {31'd0, exp_id});
            step();
            step();
            check("cont_rsp_id", {31'd0, rsp_id}, {31'd0, exp_id});
            check("cont_rsp_data", {16'd0, rsp_data}, exp_id ? 32'h0000FF00 : 32'h000000F0);
            step();
        end

        // Backpressure: last grant was req1, so req0 goes next; req1 waits.
        rsp_ready = 0;
        check("bp_ready0", {31'd0, req0_ready}, 32'd1);
        step();
        req0_valid = 0;
        step();
        check("bp_first_valid", {31'd0, rsp_valid}, 32'd1);
        for (int c = 0; c < 5; c++) begin
            step();
            check("bp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_data", {16'd0, rsp_data}, 32'h000000F0);
            check("bp_id", {31'd0, rsp_id}, 32'd0);
            check("bp_req1_ready", {31'd0, req1_ready}, 32'd0);
        end
        rsp_ready = 1;
        step();
        check("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
        check("bp_req1_granted", {31'd0, req1_ready}, 32'd1);
        step();
        req1_valid = 0;
        step();
        check("bp_req1_data", {16'd0, rsp_data}, 32'h0000FF00);
        check("bp_req1_id", {31'd0, rsp_id}, 32'd1);
        step();

        // Reset while in EXEC, then while in RESP.
        req1_valid = 1; req1_A = 16'h0005; req1_B = 16'h0003; req1_ALUK = 2'b00;
        step();
        req1_valid = 0;
        check("mid_exec_busy", {31'd0, busy}, 32'd1);
        #2 Reset_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid_rst_aluk", {30'd0, alu_ALUK}, 32'd3);
        check("mid_rst_alu_A", {16'd0, alu_A}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        #1 Reset_n = 1'b1;
        req1_valid = 1;
        step();
        req1_valid = 0;
        rsp_ready = 0;
        step();
        check("resp_before_rst", {31'd0, rsp_valid}, 32'd1);
        #2 Reset_n = 1'b0;
        #1;
        check("resp_rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("resp_rst_data", {16'd0, rsp_data}, 32'd0);
        check("resp_rst_id", {31'd0, rsp_id}, 32'd0);
        req0_valid = 1; req0_A = 16'h1234; req0_B = 16'h0000; req0_ALUK = 2'b11;
        req1_valid = 1;
        #1 Reset_n = 1'b1;
        #1;
        check("post_rst_tie0", {31'd0, req0_ready}, 32'd1);
        check("post_rst_tie1", {31'd0, req1_ready}, 32'd0);
        rsp_ready = 1;
        step();
        req0_valid = 0;
        req1_valid = 0;
        step();
        check("post_rst_data", {16'd0, rsp_data}, 32'h00001234);
        check("post_rst_id", {31'd0, rsp_id}, 32'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
